// File: rtl/la_pkg.sv
// la_pkg: capture-sequencer state encodings and register offsets shared with host software
package la_pkg;
    typedef enum logic [2:0] {
        IDLE             = 3'd0,
        DRAIN            = 3'd1,
        MOVE_TO_POSITION = 3'd2,
        IN_POSITION      = 3'd3,
        CAPTURING        = 3'd4,
        CAPTURED         = 3'd5
    } state_t;
    localparam logic [15:0] REG_STATE         = 16'd0;
    localparam logic [15:0] REG_TRIGGER_LOC   = 16'd1;
    localparam logic [15:0] REG_REQUEST_START = 16'd2;
    localparam logic [15:0] REG_REQUEST_STOP  = 16'd3;
endpackage

// File: rtl/la_fsm_if.sv
// la_fsm_if: daisy-chained register bus, inputs from upstream and registered outputs downstream
interface la_fsm_if;
    logic [15:0] addr_i, wdata_i, rdata_i;
    logic [15:0] addr_o, wdata_o, rdata_o;
    logic        rw_i, valid_i, rw_o, valid_o;
    modport master (
        output addr_i, wdata_i, rdata_i, rw_i, valid_i,
        input  addr_o, wdata_o, rdata_o, rw_o, valid_o
    );
    modport slave (
        input  addr_i, wdata_i, rdata_i, rw_i, valid_i,
        output addr_o, wdata_o, rdata_o, rw_o, valid_o
    );
endinterface

// File: rtl/la_fsm.sv
// la_fsm: logic-analyzer capture sequencer driving sample-memory acquire/pop from a bus-mapped window
module la_fsm
    import la_pkg::*;
#(
    parameter int  BASE_ADDR    = 0,
    parameter int  SAMPLE_DEPTH = 1024,
    localparam int AW           = $clog2(SAMPLE_DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trig,
    input  logic [AW:0] fifo_size,
    output logic        acquire,
    output logic        pop,
    la_fsm_if.slave     bus
);
    state_t        state_q, state_d;
    logic [AW-1:0] trigger_loc_q, trigger_loc_d;
    logic [15:0]   addr_q, wdata_q, rdata_q, rdata_d;
    logic          rw_q, valid_q;
    logic [15:0]   off;
    logic          in_win, wr, rd, start, stop;
    logic [AW:0]   tl, depth;

    assign off    = bus.addr_i - 16'(BASE_ADDR);
    assign in_win = off < 16'd4;
    assign wr     = bus.valid_i && bus.rw_i && in_win;
    assign rd     = bus.valid_i && !bus.rw_i && in_win;
    assign start  = wr && off == REG_REQUEST_START && bus.wdata_i == 16'd1;
    assign stop   = wr && off == REG_REQUEST_STOP && bus.wdata_i == 16'd1;
    assign tl     = {1'b0, trigger_loc_q};
    assign depth  = (AW+1)'(SAMPLE_DEPTH);

    assign trigger_loc_d = !(wr && off == REG_TRIGGER_LOC && state_q == IDLE) ? trigger_loc_q :
                           {16'd0, bus.wdata_i} >= 32'(SAMPLE_DEPTH) ? AW'(SAMPLE_DEPTH - 1) :
                           bus.wdata_i[AW-1:0];
    assign rdata_d = !rd ? bus.rdata_i :
                     off == REG_STATE       ? 16'(state_q) :
                     off == REG_TRIGGER_LOC ? 16'(trigger_loc_q) : 16'd0;

    always_comb begin
        state_d = state_q;
        acquire = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: if (start) state_d = fifo_size != '0 ? DRAIN : MOVE_TO_POSITION;
            DRAIN: begin
                pop = fifo_size != '0;
                if (fifo_size == '0) state_d = MOVE_TO_POSITION;
            end
            MOVE_TO_POSITION: begin
                acquire = fifo_size < tl;
                if (fifo_size == tl) state_d = IN_POSITION;
            end
            // acquire and pop together keep the pre-trigger window sliding at constant depth
            IN_POSITION: begin
                acquire = tl != '0;
                pop     = fifo_size == tl && fifo_size != '0;
                if (trig) state_d = CAPTURING;
            end
            CAPTURING: begin
                acquire = fifo_size < depth;
                if (fifo_size == depth) state_d = CAPTURED;
            end
            CAPTURED: state_d = CAPTURED;
            default:  state_d = IDLE;
        endcase
        if (stop) state_d = IDLE;
        if (rst) begin
            acquire = 1'b0;
            pop     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            trigger_loc_q <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            rw_q          <= 1'b0;
            valid_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            trigger_loc_q <= trigger_loc_d;
            addr_q        <= bus.addr_i;
            wdata_q       <= bus.wdata_i;
            rdata_q       <= rdata_d;
            rw_q          <= bus.rw_i;
            valid_q       <= bus.valid_i;
        end
    end

    assign bus.addr_o  = addr_q;
    assign bus.wdata_o = wdata_q;
    assign bus.rdata_o = rdata_q;
    assign bus.rw_o    = rw_q;
    assign bus.valid_o = valid_q;
endmodule

// File: tb/tb_la_fsm.sv
// tb_la_fsm: directed scoreboard bench for la_fsm with a behavioural sample-memory occupancy model
module tb_la_fsm;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       trig = 1'b0;
    logic [3:0] size = 4'd0;
    logic       acquire, pop;
    int         checks = 0, errors = 0, cnt;

    typedef struct {
        logic [15:0] rd;
        logic [33:0] echo;
    } exp_t;
    exp_t exp_q[$];

    la_fsm_if bus();

    la_fsm #(.BASE_ADDR(16'h40), .SAMPLE_DEPTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .trig(trig),
        .fifo_size(size),
        .acquire(acquire),
        .pop(pop),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // sample memory occupancy is not cleared by rst
    always @(posedge clk) size <= size + {3'd0, acquire} - {3'd0, pop};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input string tag, input logic [15:0] a, input logic rw,
                        input logic [15:0] wd, input logic [15:0] exp_rd);
        exp_t e;
        bus.addr_i  = a;
        bus.rw_i    = rw;
        bus.wdata_i = wd;
        bus.valid_i = 1'b1;
        e.rd   = exp_rd;
        e.echo = {a, wd, rw, 1'b1};
        exp_q.push_back(e);
        tick();
        bus.valid_i = 1'b0;
        e = exp_q.pop_front();
        chk({tag, "_rdata"}, 34'(bus.rdata_o), 34'(e.rd));
        chk({tag, "_echo"}, {bus.addr_o, bus.wdata_o, bus.rw_o, bus.valid_o}, e.echo);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.addr_i  = 16'h1234;
        bus.wdata_i = 16'h5555;
        bus.rdata_i = 16'hBEEF;
        bus.rw_i    = 1'b1;
        bus.valid_i = 1'b1;
        trig        = 1'b1;
        tick();
        tick();
        chk("rst_rdata", 34'(bus.rdata_o), 34'd0);
        chk("rst_echo", {bus.addr_o, bus.wdata_o, bus.rw_o, bus.valid_o}, 34'd0);
        chk("rst_acq_pop", {32'd0, acquire, pop}, 34'd0);
        bus.valid_i = 1'b0;
        rst = 1'b0;
        xfer("idle_trig_ignored", 16'h40, 1'b0, 16'd0, 16'd0);
        trig = 1'b0;
        xfer("idle_state", 16'h40, 1'b0, 16'd0, 16'd0);
        xfer("tloc_reset", 16'h41, 1'b0, 16'd0, 16'd0);
        xfer("out_of_window", 16'h44, 1'b0, 16'd0, 16'hBEEF);
        xfer("write_passthru", 16'h41, 1'b1, 16'd20, 16'hBEEF);
        xfer("tloc_clamp", 16'h41, 1'b0, 16'd0, 16'd7);
        xfer("tloc_set", 16'h41, 1'b1, 16'd3, 16'hBEEF);
        xfer("start_reads0", 16'h42, 1'b0, 16'd0, 16'd0);
        xfer("stop_reads0", 16'h43, 1'b0, 16'd0, 16'd0);
        xfer("start_empty", 16'h42, 1'b1, 16'd1, 16'hBEEF);
        chk("move_acq_pop", {32'd0, acquire, pop}, 34'b10);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cnt += int'(acquire);
            tick();
        end
        chk("move_acq_count", 34'(cnt), 34'd3);
        chk("inpos_acq_pop", {32'd0, acquire, pop}, 34'b11);
        chk("inpos_size", 34'(size), 34'd3);
        xfer("inpos_state", 16'h40, 1'b0, 16'd0, 16'd3);
        chk("inpos_hold", 34'(size), 34'd3);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        chk("cap_acq_pop", {32'd0, acquire, pop}, 34'b10);
        chk("pretrig_size", 34'(size), 34'd3);
        xfer("cap_tloc_write", 16'h41, 1'b1, 16'd5, 16'hBEEF);
        xfer("cap_tloc_keep", 16'h41, 1'b0, 16'd0, 16'd3);
        for (int i = 0; i < 20 && acquire; i++) tick();
        chk("cap_full", 34'(size), 34'd8);
        chk("cap_full_acq", {32'd0, acquire, pop}, 34'b00);
        tick();
        xfer("captured_state", 16'h40, 1'b0, 16'd0, 16'd5);
        chk("captured_acq_pop", {32'd0, acquire, pop}, 34'b00);
        xfer("stop_captured", 16'h43, 1'b1, 16'd1, 16'hBEEF);
        xfer("start_full", 16'h42, 1'b1, 16'd1, 16'hBEEF);
        chk("drain_acq_pop", {32'd0, acquire, pop}, 34'b01);
        cnt = 0;
        for (int i = 0; i < 20 && pop; i++) begin
            cnt++;
            tick();
        end
        chk("drain_count", 34'(cnt), 34'd8);
        tick();
        chk("move2_acq_pop", {32'd0, acquire, pop}, 34'b10);
        xfer("move2_state", 16'h40, 1'b0, 16'd0, 16'd2);
        for (int i = 0; i < 20 && !(acquire && pop); i++) tick();
        chk("inpos2_acq_pop", {32'd0, acquire, pop}, 34'b11);
        rst = 1'b1;
        #1;
        chk("rst_comb_zero", {32'd0, acquire, pop}, 34'b00);
        tick();
        rst = 1'b0;
        chk("rst_idle_zero", {32'd0, acquire, pop}, 34'b00);
        chk("rst_keeps_mem", 34'(size), 34'd3);
        xfer("rst_state", 16'h40, 1'b0, 16'd0, 16'd0);
        xfer("rst_tloc", 16'h41, 1'b0, 16'd0, 16'd0);
        xfer("start_tl0", 16'h42, 1'b1, 16'd1, 16'hBEEF);
        for (int i = 0; i < 20 && pop; i++) tick();
        tick();
        tick();
        chk("inpos_tl0_acq_pop", {32'd0, acquire, pop}, 34'b00);
        xfer("inpos_tl0_state", 16'h40, 1'b0, 16'd0, 16'd3);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20 && acquire; i++) begin
            cnt++;
            tick();
        end
        chk("cap_tl0_count", 34'(cnt), 34'd8);
        tick();
        xfer("captured_tl0_state", 16'h40, 1'b0, 16'd0, 16'd5);
        xfer("stop_again", 16'h43, 1'b1, 16'd1, 16'hBEEF);
        xfer("start_again", 16'h42, 1'b1, 16'd1, 16'hBEEF);
        for (int i = 0; i < 20 && pop; i++) tick();
        tick();
        tick();
        trig = 1'b1;
        tick();
        trig = 1'b0;
        chk("cap3_acq", {32'd0, acquire, pop}, 34'b10);
        xfer("stop_capturing", 16'h43, 1'b1, 16'd1, 16'hBEEF);
        chk("stop_acq_pop", {32'd0, acquire, pop}, 34'b00);
        xfer("stop_state", 16'h40, 1'b0, 16'd0, 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/la_fsm.md
LA_FSM -- requirements
Module: la_fsm

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 0, first bus address of its register window.
REQ-002 The block SHALL have parameter SAMPLE_DEPTH, default 1024, capacity of the downstream sample memory; AW = clog2(SAMPLE_DEPTH).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 The block SHALL have port trig, input, 1, trigger condition from the trigger block.
REQ-006 The block SHALL have port fifo_size, input, AW+1, sample memory occupancy (write pointer minus read pointer).
REQ-007 The block SHALL have port acquire, output, 1, write-one-sample strobe to the sample memory.
REQ-008 The block SHALL have port pop, output, 1, discard-oldest-sample strobe to the sample memory.
REQ-009 The block SHALL have ports addr_i, wdata_i, rdata_i, input, 16 each, and rw_i, valid_i, input, 1 each: bus input; rw_i = 1 means write.
REQ-010 The block SHALL have ports addr_o, wdata_o, rdata_o, output, 16 each, and rw_o, valid_o, output, 1 each: registered bus output.

Function
REQ-011 States: IDLE=0, DRAIN=1, MOVE_TO_POSITION=2, IN_POSITION=3, CAPTURING=4, CAPTURED=5; encoding 3 bits.
REQ-012 Register map: BASE_ADDR+0 state (read-only); +1 trigger_loc (read/write, AW bits); +2 request_start (write-only, reads 0); +3 request_stop (write-only, reads 0).
REQ-013 Bus latency: exactly 1 cycle; every bus input field SHALL be registered to its output every cycle.
REQ-014 For valid read in window: rdata_o = register value zero-extended to 16 bits; all other transactions: rdata_o = rdata_i.
REQ-015 trigger_loc write: accepted only in IDLE; a value >= SAMPLE_DEPTH is stored as SAMPLE_DEPTH-1; writes in other states are ignored.
REQ-016 Valid write of 1 to request_start in IDLE: next state DRAIN if fifo_size != 0, else MOVE_TO_POSITION; ignored outside IDLE.
REQ-017 Valid write of 1 to request_stop: next state IDLE from any state; this has priority over every other transition.
REQ-018 IDLE and CAPTURED: acquire = 0, pop = 0; no autonomous transitions.
REQ-019 DRAIN: pop = (fifo_size != 0), acquire = 0; go to MOVE_TO_POSITION when fifo_size == 0.
REQ-020 MOVE_TO_POSITION: acquire = (fifo_size < trigger_loc), pop = 0; go to IN_POSITION when fifo_size == trigger_loc.
REQ-021 IN_POSITION: acquire = (trigger_loc != 0), pop = (fifo_size == trigger_loc && fifo_size != 0); occupancy is held constant.
REQ-022 IN_POSITION: trig = 1 SHALL move the FSM to CAPTURING next cycle; the sample acquired in the trig cycle counts as pre-trigger.
REQ-023 CAPTURING: acquire = (fifo_size < SAMPLE_DEPTH), pop = 0; go to CAPTURED when fifo_size == SAMPLE_DEPTH.
REQ-024 trig SHALL be ignored in every state except IN_POSITION.
REQ-025 acquire and pop are combinational from state, fifo_size and trigger_loc; both SHALL be 0 while rst = 1.
REQ-026 fifo_size comparisons SHALL be unsigned, at AW+1 bits; trigger_loc is zero-extended to that width.

Reset
REQ-027 Reset SHALL set state = IDLE, trigger_loc = 0, and all bus outputs to 0.
REQ-028 Reset mid-capture SHALL abort to IDLE with no further acquire/pop; memory contents are not cleared.

Structure
REQ-029 State encodings and register offsets (0..3) SHALL reside in a shared la_pkg, used by this block and the host software generator.
REQ-030 Single module; no sub-module is required; the bus register decode is inline.

Verification
REQ-031 SAMPLE_DEPTH=8, trigger_loc=3, start with fifo_size=0 -> MOVE_TO_POSITION, 3 acquires, IN_POSITION with size held at 3 via acquire+pop.
REQ-032 In IN_POSITION, pulse trig -> CAPTURING next cycle, acquires until fifo_size=8, then CAPTURED with acquire=0.
REQ-033 Start with fifo_size=8 (prior capture) -> DRAIN, 8 pops, then MOVE_TO_POSITION.
REQ-034 trigger_loc=0, start -> IN_POSITION with no acquire/pop; trig -> 8 acquires -> CAPTURED.
REQ-035 Write trigger_loc=20 (SAMPLE_DEPTH=8) -> reads back 7; write in CAPTURING -> value unchanged.
REQ-036 request_stop in CAPTURING and rst in IN_POSITION -> IDLE next cycle; acquire=pop=0; bus read of +0 returns 0 after 1 cycle.
